// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: 2-flop synchronizer, 3-sample majority vote, LSB-first deserializer.
// Optional saturating error counter on err_count when UART_RX_ERR_CNT_EN is defined.
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  parity_en,
  input  logic                  parity_type,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  busy
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0]            err_count
`endif
);

  // state  | meaning
  // IDLE   | line idle, waiting for an armed falling edge
  // START  | qualifying the start bit (glitch -> IDLE)
  // DATA   | shifting in DATA_WIDTH bits, LSB first
  // PARITY | checking the parity bit
  // STOP   | sampling the stop bit, issuing the result pulse
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  localparam int EW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [EW-1:0] SAMP0     = EW'(OVERSAMPLE/2 - 3);
  localparam logic [EW-1:0] SAMP1     = EW'(OVERSAMPLE/2 - 2);
  localparam logic [EW-1:0] DECIDE    = EW'(OVERSAMPLE/2 - 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic                  sync1_q, sync1_d;
  logic                  rx_s_q, rx_s_d;
  logic [EW-1:0]         edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [1:0]            samp_q, samp_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  perr_q, perr_d;
  logic                  armed_q, armed_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_error_q, parity_error_d;
  logic                  framing_error_q, framing_error_d;

  logic decide;
  logic bit_end;
  logic bit_val;

  assign decide  = (edge_cnt_q == DECIDE);
  assign bit_end = (edge_cnt_q == LAST_EDGE);
  // Third vote is the live synchronized sample taken at the decision point.
  assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

  always_comb begin
    sync1_d         = rx_in;
    rx_s_d          = sync1_q;
    state_d         = state_q;
    edge_cnt_d      = edge_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    samp_d          = samp_q;
    shift_d         = shift_q;
    par_en_d        = par_en_q;
    par_type_d      = par_type_q;
    perr_d          = perr_q;
    armed_d         = armed_q;
    p_data_d        = p_data_q;
    data_valid_d    = 1'b0;
    parity_error_d  = 1'b0;
    framing_error_d = 1'b0;

    if (state_q != IDLE) begin
      edge_cnt_d = bit_end ? '0 : edge_cnt_q + EW'(1);
      if (edge_cnt_q == SAMP0) samp_d[0] = rx_s_q;
      if (edge_cnt_q == SAMP1) samp_d[1] = rx_s_q;
    end

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d    = START;
          par_en_d   = parity_en;
          par_type_d = parity_type;
          perr_d     = 1'b0;
        end
      end
      START: begin
        if (decide && bit_val) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
        end else if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (decide) shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (decide && (bit_val != (^shift_q ^ par_type_q))) perr_d = 1'b1;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is caught on time.
        if (decide) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
          if (!bit_val) begin
            framing_error_d = 1'b1;
            armed_d         = 1'b0;
          end else if (perr_q) begin
            parity_error_d = 1'b1;
          end else begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      sync1_q         <= 1'b1;
      rx_s_q          <= 1'b1;
      edge_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      samp_q          <= '0;
      shift_q         <= '0;
      par_en_q        <= 1'b0;
      par_type_q      <= 1'b0;
      perr_q          <= 1'b0;
      armed_q         <= 1'b1;
      p_data_q        <= '0;
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      sync1_q         <= sync1_d;
      rx_s_q          <= rx_s_d;
      edge_cnt_q      <= edge_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      samp_q          <= samp_d;
      shift_q         <= shift_d;
      par_en_q        <= par_en_d;
      par_type_q      <= par_type_d;
      perr_q          <= perr_d;
      armed_q         <= armed_d;
      p_data_q        <= p_data_d;
      data_valid_q    <= data_valid_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
    end
  end

  assign p_data        = p_data_q;
  assign data_valid    = data_valid_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;
  assign busy          = (state_q != IDLE);

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((parity_error_d || framing_error_d) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_cnt_q <= '0;
    else      err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule
